// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath.
//   - conv_state_e : address-generator FSM states
//   - KS_W         : width of the kernel-size / stride fields
//   - INFO_*       : bit positions inside the per-job info word,
//                    also decoded by the convolution read mux
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2
  } conv_state_e;

  localparam int KS_W = 3;

  localparam int INFO_RAM_SEL = 4;
  localparam int INFO_MEM_SEL = 3;
  localparam int INFO_CH_MSB  = 2;
  localparam int INFO_CH_LSB  = 0;

endpackage

// File: rtl/conv_win_addr_gen.sv
// Feature-map read-address generator.
// Walks a KxK window over an HxW row-major map at stride S and emits one
// RAM word address per beat on a valid/ready stream.
//
// Ports
//   clk, rst            clock, async active-high reset
//   cfg_start           one-cycle job start pulse (ignored while busy)
//   cfg_base/width/height/ksize/stride/info   job configuration
//   m_addr, m_addr_first, m_addr_last, m_addr_valid, m_addr_ready
//                       address stream; first/last mark window edges
//   info                cfg_info latched at start
//   busy                high in SETUP or RUN
//   done                pulse after the final address handshake
//   cfg_err             pulse when a start is rejected
module conv_win_addr_gen
  import conv_pkg::*;
#(
  parameter int AW   = 13,
  parameter int DIMW = 8,
  parameter int IFW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic [AW-1:0]   cfg_base,
  input  logic [DIMW-1:0] cfg_width,
  input  logic [DIMW-1:0] cfg_height,
  input  logic [2:0]      cfg_ksize,
  input  logic [2:0]      cfg_stride,
  input  logic [IFW-1:0]  cfg_info,
  output logic [AW-1:0]   m_addr,
  output logic            m_addr_first,
  output logic            m_addr_last,
  output logic            m_addr_valid,
  input  logic            m_addr_ready,
  output logic [IFW-1:0]  info,
  output logic            busy,
  output logic            done,
  output logic            cfg_err
);

  conv_state_e state_q, state_d;

  logic [AW-1:0]   base_q, base_d;
  logic [DIMW-1:0] w_q, w_d, h_q, h_d;
  logic [2:0]      k_q, k_d, s_q, s_d;
  logic [IFW-1:0]  info_q, info_d;

  // S*W, built up one add per SETUP cycle
  logic [AW-1:0]   sw_q, sw_d;
  logic [2:0]      scnt_q, scnt_d;

  logic [2:0]      kx_q, kx_d, ky_q, ky_d;
  logic [DIMW-1:0] wx_q, wx_d, wy_q, wy_d;

  // line_base -> map(wy,0); win_base -> map(wy,wx); row_ptr -> map(wy+ky,wx)
  logic [AW-1:0]   line_base_q, line_base_d;
  logic [AW-1:0]   win_base_q, win_base_d;
  logic [AW-1:0]   row_ptr_q, row_ptr_d;

  logic [AW-1:0]   addr_q, addr_d;
  logic            first_q, first_d, last_q, last_d, valid_q, valid_d;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic            cfg_legal;
  logic            xfer;
  logic            kx_end, ky_end, kx_pre_end;
  logic            win_fits_x, win_fits_y;
  logic [DIMW:0]   wx_reach, wy_reach;

  assign cfg_legal = (cfg_ksize != 3'd0) && (cfg_stride != 3'd0) &&
                     ({{(DIMW-3){1'b0}}, cfg_ksize} <= cfg_width) &&
                     ({{(DIMW-3){1'b0}}, cfg_ksize} <= cfg_height);

  assign xfer       = valid_q && m_addr_ready;
  assign kx_end     = (kx_q == k_q - 3'd1);
  assign ky_end     = (ky_q == k_q - 3'd1);
  assign kx_pre_end = (kx_q + 3'd1 == k_q - 3'd1);

  // Right/bottom edge of the *next* window position, one bit wider so the
  // compare against W/H cannot wrap.
  assign wx_reach   = {1'b0, wx_q} + {{(DIMW-2){1'b0}}, s_q} + {{(DIMW-2){1'b0}}, k_q};
  assign wy_reach   = {1'b0, wy_q} + {{(DIMW-2){1'b0}}, s_q} + {{(DIMW-2){1'b0}}, k_q};
  assign win_fits_x = (wx_reach <= {1'b0, w_q});
  assign win_fits_y = (wy_reach <= {1'b0, h_q});

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    w_d         = w_q;
    h_d         = h_q;
    k_d         = k_q;
    s_d         = s_q;
    info_d      = info_q;
    sw_d        = sw_q;
    scnt_d      = scnt_q;
    kx_d        = kx_q;
    ky_d        = ky_q;
    wx_d        = wx_q;
    wy_d        = wy_q;
    line_base_d = line_base_q;
    win_base_d  = win_base_q;
    row_ptr_d   = row_ptr_q;
    addr_d      = addr_q;
    first_d     = first_q;
    last_d      = last_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_legal) begin
            state_d = SETUP;
            base_d  = cfg_base;
            w_d     = cfg_width;
            h_d     = cfg_height;
            k_d     = cfg_ksize;
            s_d     = cfg_stride;
            info_d  = cfg_info;
            sw_d    = '0;
            scnt_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      SETUP: begin
        sw_d   = sw_q + {{(AW-DIMW){1'b0}}, w_q};
        scnt_d = scnt_q + 3'd1;
        // Last add: present the first beat so it is valid in the next cycle.
        if (scnt_q == s_q - 3'd1) begin
          state_d     = RUN;
          kx_d        = '0;
          ky_d        = '0;
          wx_d        = '0;
          wy_d        = '0;
          line_base_d = base_q;
          win_base_d  = base_q;
          row_ptr_d   = base_q;
          addr_d      = base_q;
          first_d     = 1'b1;
          last_d      = (k_q == 3'd1);
          valid_d     = 1'b1;
        end
      end

      RUN: begin
        if (xfer) begin
          if (!kx_end) begin
            kx_d    = kx_q + 3'd1;
            addr_d  = addr_q + {{(AW-1){1'b0}}, 1'b1};
            first_d = 1'b0;
            last_d  = ky_end && kx_pre_end;
          end else if (!ky_end) begin
            // K >= 2 here, so the new beat can be neither first nor last
            kx_d      = '0;
            ky_d      = ky_q + 3'd1;
            row_ptr_d = row_ptr_q + {{(AW-DIMW){1'b0}}, w_q};
            addr_d    = row_ptr_q + {{(AW-DIMW){1'b0}}, w_q};
            first_d   = 1'b0;
            last_d    = 1'b0;
          end else if (win_fits_x) begin
            kx_d       = '0;
            ky_d       = '0;
            wx_d       = wx_q + {{(DIMW-3){1'b0}}, s_q};
            win_base_d = win_base_q + {{(AW-3){1'b0}}, s_q};
            row_ptr_d  = win_base_q + {{(AW-3){1'b0}}, s_q};
            addr_d     = win_base_q + {{(AW-3){1'b0}}, s_q};
            first_d    = 1'b1;
            last_d     = (k_q == 3'd1);
          end else if (win_fits_y) begin
            kx_d        = '0;
            ky_d        = '0;
            wx_d        = '0;
            wy_d        = wy_q + {{(DIMW-3){1'b0}}, s_q};
            line_base_d = line_base_q + sw_q;
            win_base_d  = line_base_q + sw_q;
            row_ptr_d   = line_base_q + sw_q;
            addr_d      = line_base_q + sw_q;
            first_d     = 1'b1;
            last_d      = (k_q == 3'd1);
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      w_q         <= '0;
      h_q         <= '0;
      k_q         <= '0;
      s_q         <= '0;
      info_q      <= '0;
      sw_q        <= '0;
      scnt_q      <= '0;
      kx_q        <= '0;
      ky_q        <= '0;
      wx_q        <= '0;
      wy_q        <= '0;
      line_base_q <= '0;
      win_base_q  <= '0;
      row_ptr_q   <= '0;
      addr_q      <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      w_q         <= w_d;
      h_q         <= h_d;
      k_q         <= k_d;
      s_q         <= s_d;
      info_q      <= info_d;
      sw_q        <= sw_d;
      scnt_q      <= scnt_d;
      kx_q        <= kx_d;
      ky_q        <= ky_d;
      wx_q        <= wx_d;
      wy_q        <= wy_d;
      line_base_q <= line_base_d;
      win_base_q  <= win_base_d;
      row_ptr_q   <= row_ptr_d;
      addr_q      <= addr_d;
      first_q     <= first_d;
      last_q      <= last_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign m_addr       = addr_q;
  assign m_addr_first = first_q;
  assign m_addr_last  = last_q;
  assign m_addr_valid = valid_q;
  assign info         = info_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = err_q;

endmodule

// File: tb/tb_conv_win_addr_gen.sv
module tb_conv_win_addr_gen;
  localparam int AW = 13, DIMW = 8, IFW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_start = 1'b0;
  logic [AW-1:0]   cfg_base = '0;
  logic [DIMW-1:0] cfg_width = '0, cfg_height = '0;
  logic [2:0]      cfg_ksize = '0, cfg_stride = '0;
  logic [IFW-1:0]  cfg_info = '0;
  logic [AW-1:0]   m_addr;
  logic            m_addr_first, m_addr_last, m_addr_valid;
  logic            m_addr_ready = 1'b0;
  logic [IFW-1:0]  info;
  logic            busy, done, cfg_err;

  int n_chk = 0, n_err = 0;
  int g_addr[$];
  bit g_first[$], g_last[$];

  conv_win_addr_gen #(.AW(AW), .DIMW(DIMW), .IFW(IFW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base(cfg_base),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_ksize(cfg_ksize),
    .cfg_stride(cfg_stride), .cfg_info(cfg_info), .m_addr(m_addr),
    .m_addr_first(m_addr_first), .m_addr_last(m_addr_last),
    .m_addr_valid(m_addr_valid), .m_addr_ready(m_addr_ready), .info(info),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_outs"}, {m_addr, m_addr_first, m_addr_last, m_addr_valid,
                         info, busy, done, cfg_err}, 0);
  endtask

  // Runs one job and checks it against a direct-formula window walk.
  task automatic run_job(input int base, input int w, input int h, input int k,
                         input int s, input int inf, input bit rnd, input bit inject);
    int  ea[$];
    bit  ef[$], el[$];
    int  lat = -1;
    bit  prev_stall = 0, fin = 0;
    logic [AW-1:0] pa;
    logic pf = 0, pl = 0;
    for (int wy = 0; wy + k <= h; wy += s)
      for (int wx = 0; wx + k <= w; wx += s)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            ea.push_back((base + (wy + ky) * w + wx + kx) % (1 << AW));
            ef.push_back(kx == 0 && ky == 0);
            el.push_back(kx == k - 1 && ky == k - 1);
          end
    g_addr.delete(); g_first.delete(); g_last.delete();
    pa = '0;
    @(negedge clk);
    cfg_base = AW'(base); cfg_width = DIMW'(w); cfg_height = DIMW'(h);
    cfg_ksize = 3'(k); cfg_stride = 3'(s); cfg_info = IFW'(inf);
    cfg_start = 1'b1;
    @(posedge clk);
    #1 cfg_start = 1'b0;
    for (int cyc = 1; cyc <= 3000 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 1) chk("busy_t1", busy, 1);
      if (cyc == 1) chk("info", info, inf);
      if (inject && cyc == 3) chk("no_err_when_busy", cfg_err, 0);
      if (m_addr_valid && lat < 0) lat = cyc;
      if (prev_stall) begin
        chk("stall_addr", m_addr, pa);
        chk("stall_first", m_addr_first, pf);
        chk("stall_last", m_addr_last, pl);
        chk("stall_valid", m_addr_valid, 1);
      end
      if (g_addr.size() == ea.size()) begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_valid", m_addr_valid, 0);
        fin = 1;
      end else begin
        m_addr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (inject) begin
          cfg_start = (cyc == 2);
          cfg_base  = (cyc == 2) ? AW'(500) : cfg_base;
        end
        if (m_addr_valid && m_addr_ready) begin
          g_addr.push_back(int'(m_addr));
          g_first.push_back(m_addr_first);
          g_last.push_back(m_addr_last);
        end
        prev_stall = m_addr_valid && !m_addr_ready;
        pa = m_addr; pf = m_addr_first; pl = m_addr_last;
      end
    end
    m_addr_ready = 1'b0;
    cfg_start = 1'b0;
    if (!fin) chk("job_timeout", 0, 1);
    chk("first_valid_latency", lat, s + 1);
    chk("nbeats", g_addr.size(), ea.size());
    for (int i = 0; i < ea.size() && i < g_addr.size(); i++) begin
      chk($sformatf("addr[%0d]", i), g_addr[i], ea[i]);
      chk($sformatf("first[%0d]", i), g_first[i], ef[i]);
      chk($sformatf("last[%0d]", i), g_last[i], el[i]);
    end
  endtask

  initial begin
    int win1[9];
    win1 = '{100, 101, 102, 104, 105, 106, 108, 109, 110};

    // reset state
    #12;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("post_reset");

    // W4 H4 K3 S1 base 100, continuous ready
    run_job(100, 4, 4, 3, 1, 5'h15, 1'b0, 1'b0);
    if (g_addr.size() == 36) begin
      for (int i = 0; i < 9; i++) chk("t1_first_window", g_addr[i], win1[i]);
      chk("t1_winbase1", g_addr[9], 101);
      chk("t1_winbase2", g_addr[18], 104);
      chk("t1_winbase3", g_addr[27], 105);
      chk("t1_final", g_addr[35], 115);
      chk("t1_final_last", g_last[35], 1);
    end else chk("t1_len", g_addr.size(), 36);

    // same job with stalls
    run_job(100, 4, 4, 3, 1, 5'h0a, 1'b1, 1'b0);

    // W5 H5 K2 S2 base 0, with a start pulse while busy
    run_job(0, 5, 5, 2, 2, 5'h03, 1'b0, 1'b1);
    if (g_addr.size() == 16) begin
      chk("t3_wb0", g_addr[0], 0);
      chk("t3_wb1", g_addr[4], 2);
      chk("t3_wb2", g_addr[8], 10);
      chk("t3_wb3", g_addr[12], 12);
    end else chk("t3_len", g_addr.size(), 16);
    @(negedge clk);
    chk("t3_no_restart", busy, 0);

    // K1 address wrap at 2^AW
    run_job(8190, 3, 1, 1, 1, 5'h1f, 1'b1, 1'b0);
    if (g_addr.size() == 3) begin
      chk("wrap0", g_addr[0], 8190);
      chk("wrap1", g_addr[1], 8191);
      chk("wrap2", g_addr[2], 0);
      for (int i = 0; i < 3; i++) chk("wrap_fl", {g_first[i], g_last[i]}, 2'b11);
    end else chk("wrap_len", g_addr.size(), 3);

    // illegal config K4 > W3
    @(negedge clk);
    cfg_ksize = 3'd4; cfg_stride = 3'd1; cfg_width = 8'd3; cfg_height = 8'd3;
    cfg_start = 1'b1;
    @(posedge clk);
    #1 cfg_start = 1'b0;
    @(negedge clk);
    chk("err_pulse", cfg_err, 1);
    chk("err_busy", busy, 0);
    chk("err_valid", m_addr_valid, 0);
    @(negedge clk);
    chk("err_one_cycle", cfg_err, 0);
    repeat (3) begin
      @(negedge clk);
      chk("err_no_valid", {m_addr_valid, busy}, 0);
    end

    // reset mid-job
    @(negedge clk);
    cfg_base = 13'd40; cfg_width = 8'd6; cfg_height = 8'd6;
    cfg_ksize = 3'd3; cfg_stride = 3'd1; cfg_info = 5'h11;
    cfg_start = 1'b1;
    @(posedge clk);
    #1 cfg_start = 1'b0;
    m_addr_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_job_valid", m_addr_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk_idle_outputs("async_rst");
    m_addr_ready = 1'b0;
    @(negedge clk);
    chk_idle_outputs("held_rst");
    rst = 1'b0;
    @(negedge clk);
    chk("rst_no_done", done, 0);
    run_job(7, 4, 3, 2, 1, 5'h09, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
